imem_load_arbiter: RTL

//  Owns the single port of the synchronous instruction memory (INST_MEM_SIZE words). After reset it

---
 rtl/imem_load_arbiter_if.sv | 40 ++++
 rtl/imem_load_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_load_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter and its neighbours:
// the IF stage (fetch_*), the boot/debug loader (ld_*) and the memory array (mem_*).
// The arbiter uses the slave modport; the surrounding environment uses master.
interface imem_load_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) ();
    // IF stage
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;
    logic              cpu_hold;
    // boot/debug loader
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_rdata, fetch_err, cpu_hold, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_rdata, fetch_err, cpu_hold, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// Single-port instruction memory owner: zero-fills the array after reset, takes the
// boot image from the loader, then serves CPU fetches. In RUN a loader write beats a fetch.
module imem_load_arbiter #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_load_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] last_q;

    logic              fetch_bad_s;
    logic              gnt_s;
    logic              ld_ready_s;
    logic              cpu_hold_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rdata_s;

    // A fetch address is unusable when it is not word aligned or lies beyond the array.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    assign fetch_bad_s = addr_bad(bus.fetch_addr);

    // State register and zero-fill counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: CLEAR walks every index once, LOAD waits for ld_done, RUN is terminal.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_LOAD: begin
                if (bus.ld_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Output decode: memory port steering, handshakes and CPU hold; forced idle while in reset.
    always_comb begin
        gnt_s       = 1'b0;
        ld_ready_s  = 1'b0;
        cpu_hold_s  = 1'b1;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = NOP_WORD;
        if (!rst_n) begin
            gnt_s = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_en_s    = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = clr_cnt_q;
                    mem_wdata_s = NOP_WORD;
                end
                ST_LOAD: begin
                    ld_ready_s = 1'b1;
                    if (bus.ld_valid) begin
                        mem_en_s    = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = bus.ld_addr;
                        mem_wdata_s = bus.ld_data;
                    end else begin
                        mem_en_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    cpu_hold_s = 1'b0;
                    ld_ready_s = 1'b1;
                    if (bus.ld_valid) begin
                        mem_en_s    = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = bus.ld_addr;
                        mem_wdata_s = bus.ld_data;
                    end else if (bus.fetch_req) begin
                        gnt_s      = 1'b1;
                        mem_addr_s = bus.fetch_addr[ADDR_W+1:2];
                        mem_en_s   = !fetch_bad_s;  // bad addresses never touch the array
                    end else begin
                        gnt_s = 1'b0;
                    end
                end
                default: begin
                    gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch response pipeline: a grant produces exactly one valid cycle on the next clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= gnt_s;
            err_q   <= gnt_s & fetch_bad_s;
            last_q  <= rdata_s;
        end
    end

    // Read data mux: fresh memory word, NOP for a rejected address, or the held last word.
    always_comb begin
        rdata_s = last_q;
        if (valid_q) begin
            if (err_q) begin
                rdata_s = NOP_WORD;
            end else begin
                rdata_s = bus.mem_rdata;
            end
        end else begin
            rdata_s = last_q;
        end
    end

    assign bus.fetch_gnt   = gnt_s;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.fetch_rdata = rdata_s;
    assign bus.cpu_hold    = cpu_hold_s;
    assign bus.ld_ready    = ld_ready_s;
    assign bus.mem_en      = mem_en_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
endmodule
